writeback_register_file: RTL and testbench

- Write-back stage plus architectural register file. It sits directly downstream of the MEM/WB pipeline register and consumes that register's outputs.
- Selects the write-back value (memory load data or ALU/link result) and commits it to a 32x32 register file.
- Serves the two decode-stage read ports, with write-first internal bypass so ID sees the value being written this cycle.
- Exposes the selected write-back value and a committed-write counter for forwarding and debug.

---
 rtl/writeback_register_file.sv | 64 ++++++
 tb/tb_writeback_register_file.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_register_file.sv
// Write-back value select plus 32-entry architectural register file with
// write-first bypass on both decode read ports and a committed-write counter.
module writeback_register_file #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           SP_INDEX   = 29,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = 32'h0000_0FFC
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  RegWriteIn,
  input  logic [4:0]            DstAddrIn,
  input  logic                  MemToRegIn,
  input  logic [DATA_WIDTH-1:0] ReadDataIn,
  input  logic [DATA_WIDTH-1:0] DataToRegIn,
  input  logic [4:0]            ReadAddrA,
  input  logic [4:0]            ReadAddrB,
  output logic [DATA_WIDTH-1:0] ReadDataA,
  output logic [DATA_WIDTH-1:0] ReadDataB,
  output logic [DATA_WIDTH-1:0] WBDataOut,
  output logic                  WBValidOut,
  output logic [31:0]           WriteCount
);

  logic [DATA_WIDTH-1:0] regFile [32];
  logic [31:0]           writeCnt;
  logic                  commit;

  assign WBDataOut  = MemToRegIn ? ReadDataIn : DataToRegIn;
  assign commit     = RegWriteIn && (DstAddrIn != 5'd0);
  // Rst_n gates the bypass so reads during reset show the reset contents.
  assign WBValidOut = commit && Rst_n;
  assign WriteCount = writeCnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regFile[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end
      writeCnt <= '0;
    end else if (commit) begin
      regFile[DstAddrIn] <= WBDataOut;
      writeCnt           <= writeCnt + 32'd1;
    end
  end

  always_comb begin
    ReadDataA = regFile[ReadAddrA];
    if (ReadAddrA == 5'd0) begin
      ReadDataA = '0;
    end else if (WBValidOut && (ReadAddrA == DstAddrIn)) begin
      ReadDataA = WBDataOut;
    end
  end

  always_comb begin
    ReadDataB = regFile[ReadAddrB];
    if (ReadAddrB == 5'd0) begin
      ReadDataB = '0;
    end else if (WBValidOut && (ReadAddrB == DstAddrIn)) begin
      ReadDataB = WBDataOut;
    end
  end

endmodule

// File: tb/tb_writeback_register_file.sv
// Directed bench for writeback_register_file: reset, mux/commit, bypass,
// register zero, mid-stream reset and counter wrap.
module tb_writeback_register_file;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        RegWriteIn = 1'b0;
  logic [4:0]  DstAddrIn = '0;
  logic        MemToRegIn = 1'b0;
  logic [31:0] ReadDataIn = '0;
  logic [31:0] DataToRegIn = '0;
  logic [4:0]  ReadAddrA = '0;
  logic [4:0]  ReadAddrB = '0;
  logic [31:0] ReadDataA;
  logic [31:0] ReadDataB;
  logic [31:0] WBDataOut;
  logic        WBValidOut;
  logic [31:0] WriteCount;

  int unsigned nCompared = 0;
  int unsigned nMismatched = 0;

  writeback_register_file #(
    .DATA_WIDTH(32),
    .SP_INDEX(29),
    .SP_RESET(32'h0000_0FFC)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .RegWriteIn(RegWriteIn),
    .DstAddrIn(DstAddrIn),
    .MemToRegIn(MemToRegIn),
    .ReadDataIn(ReadDataIn),
    .DataToRegIn(DataToRegIn),
    .ReadAddrA(ReadAddrA),
    .ReadAddrB(ReadAddrB),
    .ReadDataA(ReadDataA),
    .ReadDataB(ReadDataB),
    .WBDataOut(WBDataOut),
    .WBValidOut(WBValidOut),
    .WriteCount(WriteCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // Reset with no clock edge: first posedge is at t=5.
    #1;
    RegWriteIn  = 1'b1;
    DstAddrIn   = 5'd7;
    DataToRegIn = 32'h0BAD_0BAD;
    Rst_n       = 1'b0;
    ReadAddrA   = 5'd29;
    ReadAddrB   = 5'd5;
    #1;
    check("rst_sp", ReadDataA, 32'h0000_0FFC);
    check("rst_r5", ReadDataB, 32'h0);
    check("rst_cnt", WriteCount, 32'h0);
    check("rst_valid", {31'b0, WBValidOut}, 32'h0);
    ReadAddrA = 5'd7;
    #1;
    check("rst_nobypass", ReadDataA, 32'h0);

    // Clock edge while in reset must not commit.
    tick();
    RegWriteIn = 1'b0;
    #1;
    check("rst_edge_r7", ReadDataA, 32'h0);
    check("rst_edge_cnt", WriteCount, 32'h0);
    Rst_n = 1'b1;
    tick();

    // Load path select and commit.
    RegWriteIn  = 1'b1;
    DstAddrIn   = 5'd8;
    MemToRegIn  = 1'b1;
    ReadDataIn  = 32'hDEAD_BEEF;
    DataToRegIn = 32'h0000_1234;
    #1;
    check("wb_mux_mem", WBDataOut, 32'hDEAD_BEEF);
    check("wb_valid", {31'b0, WBValidOut}, 32'h1);
    tick();
    RegWriteIn = 1'b0;
    ReadAddrA  = 5'd8;
    ReadAddrB  = 5'd8;
    #1;
    check("commit_r8", ReadDataA, 32'hDEAD_BEEF);
    check("same_addr_b", ReadDataB, 32'hDEAD_BEEF);
    check("cnt_1", WriteCount, 32'd1);

    // ALU path select.
    RegWriteIn = 1'b1;
    DstAddrIn  = 5'd9;
    MemToRegIn = 1'b0;
    #1;
    check("wb_mux_alu", WBDataOut, 32'h0000_1234);
    tick();
    RegWriteIn = 1'b0;
    ReadAddrB  = 5'd9;
    #1;
    check("commit_r9", ReadDataB, 32'h0000_1234);
    check("cnt_2", WriteCount, 32'd2);

    // Bypass: no write shows old value, write shows new value on both ports.
    DstAddrIn   = 5'd12;
    DataToRegIn = 32'hA5A5_A5A5;
    ReadAddrA   = 5'd12;
    ReadAddrB   = 5'd12;
    #1;
    check("nobyp_a", ReadDataA, 32'h0);
    check("nobyp_b", ReadDataB, 32'h0);
    RegWriteIn = 1'b1;
    #1;
    check("byp_a", ReadDataA, 32'hA5A5_A5A5);
    check("byp_b", ReadDataB, 32'hA5A5_A5A5);
    tick();
    check("cnt_3", WriteCount, 32'd3);

    // Disabled write with unknown data leaves state intact.
    RegWriteIn = 1'b0;
    MemToRegIn = 1'b1;
    ReadDataIn = 'x;
    tick();
    check("x_hold_r12", ReadDataA, 32'hA5A5_A5A5);
    check("x_hold_cnt", WriteCount, 32'd3);

    // Register zero.
    RegWriteIn  = 1'b1;
    DstAddrIn   = 5'd0;
    MemToRegIn  = 1'b0;
    ReadDataIn  = 32'h0;
    DataToRegIn = 32'hFFFF_FFFF;
    ReadAddrA   = 5'd0;
    #1;
    check("r0_pre", ReadDataA, 32'h0);
    check("r0_valid", {31'b0, WBValidOut}, 32'h0);
    tick();
    check("r0_post", ReadDataA, 32'h0);
    check("r0_cnt", WriteCount, 32'd3);

    // Mid-operation reset discards the pending write to reg 4.
    DstAddrIn   = 5'd3;
    DataToRegIn = 32'h0000_0055;
    tick();
    check("w_r3_cnt", WriteCount, 32'd4);
    DstAddrIn   = 5'd4;
    DataToRegIn = 32'h0000_0077;
    ReadAddrA   = 5'd3;
    ReadAddrB   = 5'd4;
    #1;
    check("pre_rst_r3", ReadDataA, 32'h0000_0055);
    Rst_n = 1'b0;
    #1;
    check("mid_rst_r3", ReadDataA, 32'h0);
    check("mid_rst_r4", ReadDataB, 32'h0);
    check("mid_rst_cnt", WriteCount, 32'h0);
    ReadAddrA = 5'd29;
    #1;
    check("mid_rst_sp", ReadDataA, 32'h0000_0FFC);
    tick();
    Rst_n     = 1'b1;
    ReadAddrA = 5'd3;
    tick();
    RegWriteIn = 1'b0;
    #1;
    check("post_rst_r4", ReadDataB, 32'h0000_0077);
    check("post_rst_r3", ReadDataA, 32'h0);
    check("post_rst_cnt", WriteCount, 32'd1);

    // Counter wrap via deposit on the internal counter.
    force dut.writeCnt = 32'hFFFF_FFFF;
    #1;
    release dut.writeCnt;
    #1;
    check("wrap_pre", WriteCount, 32'hFFFF_FFFF);
    RegWriteIn  = 1'b1;
    DstAddrIn   = 5'd20;
    DataToRegIn = 32'h0000_0001;
    tick();
    RegWriteIn = 1'b0;
    ReadAddrA  = 5'd20;
    #1;
    check("wrap_cnt", WriteCount, 32'h0);
    check("wrap_r20", ReadDataA, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
